// File: rtl/osd_msg_writer.sv
// Drives the OSD host port (io_osd/io_strobe/io_din) from the core side: bitmap line
// writes fetched from an external byte memory, plus one-word enable/disable commands.
module osd_msg_writer #(
  parameter int LINES    = 8,
  parameter int STROBE_W = 2,
  parameter int GAP      = 4,
  parameter int AW       = 11
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          req_write,
  input  logic          req_en,
  input  logic          req_dis,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_data,
  output logic          io_osd,
  output logic          io_strobe,
  output logic [15:0]   io_din
);

  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
  localparam logic [15:0] SW_LAST   = 16'(STROBE_W - 1);
  localparam logic [4:0]  LINE_LAST = 5'(LINES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WHI, S_WLO, S_POST} state_t;
  typedef enum logic [1:0] {K_WR, K_EN, K_DIS} kind_t;

  state_t      r_state;
  kind_t       r_kind;
  logic [15:0] r_cnt;
  logic [8:0]  r_word;
  logic [4:0]  r_line;
  logic [7:0]  r_byte;
  logic        r_p_wr;
  logic        r_p_en;
  logic        r_p_dis;

  logic        w_dis;
  logic        w_en;
  logic        w_wr;
  logic [8:0]  w_last_word;
  logic [7:0]  w_byte;
  logic [4:0]  w_line_inc;
  logic [12:0] w_addr;

  // A request arriving while idle is served on the very next cycle.
  assign w_dis       = r_p_dis | req_dis;
  assign w_en        = r_p_en  | req_en;
  assign w_wr        = r_p_wr  | req_write;
  assign w_last_word = (r_kind == K_WR) ? 9'd256 : 9'd0;
  // With a 2-cycle low phase the capture cycle is also the update cycle.
  assign w_byte      = (r_cnt == 16'd1) ? src_data : r_byte;
  assign w_line_inc  = r_line + 5'd1;
  assign w_addr      = {r_line, r_word[7:0]};

  assign busy = (r_state != S_IDLE) | r_p_wr | r_p_en | r_p_dis;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kind    <= K_WR;
      r_cnt     <= 16'd0;
      r_word    <= 9'd0;
      r_line    <= 5'd0;
      r_byte    <= 8'd0;
      r_p_wr    <= 1'b0;
      r_p_en    <= 1'b0;
      r_p_dis   <= 1'b0;
      done      <= 1'b0;
      src_addr  <= '0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= 16'd0;
    end else begin
      done    <= 1'b0;
      r_p_wr  <= r_p_wr  | req_write;
      r_p_en  <= r_p_en  | req_en;
      r_p_dis <= r_p_dis | req_dis;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= 16'd0;
          r_word <= 9'd0;
          r_line <= 5'd0;
          if (w_dis) begin
            r_p_dis <= 1'b0;
            r_kind  <= K_DIS;
            io_din  <= 16'h0040;
            io_osd  <= 1'b1;
            r_state <= S_PRE;
          end else if (w_en) begin
            r_p_en  <= 1'b0;
            r_kind  <= K_EN;
            io_din  <= 16'h0041;
            io_osd  <= 1'b1;
            r_state <= S_PRE;
          end else if (w_wr) begin
            r_p_wr  <= 1'b0;
            r_kind  <= K_WR;
            io_din  <= 16'h0020;
            io_osd  <= 1'b1;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt     <= 16'd0;
            io_strobe <= 1'b1;
            r_state   <= S_WHI;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WHI: begin
          if (r_cnt == SW_LAST) begin
            r_cnt     <= 16'd0;
            io_strobe <= 1'b0;
            r_state   <= S_WLO;
            // Word k>=1 carries byte k-1, so the word just sent indexes the next byte.
            if (r_word != w_last_word) begin
              src_addr <= AW'(w_addr);
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WLO: begin
          if (r_cnt == 16'd1) begin
            r_byte <= src_data;
          end
          if (r_cnt == SW_LAST) begin
            r_cnt <= 16'd0;
            if (r_word != w_last_word) begin
              r_word    <= r_word + 9'd1;
              io_din    <= {8'h00, w_byte};
              io_strobe <= 1'b1;
              r_state   <= S_WHI;
            end else begin
              io_osd  <= 1'b0;
              r_state <= S_POST;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_POST: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= 16'd0;
            if (r_kind == K_WR && r_line != LINE_LAST) begin
              r_line  <= w_line_inc;
              r_word  <= 9'd0;
              io_din  <= {8'h00, 3'b001, w_line_inc};
              io_osd  <= 1'b1;
              r_state <= S_PRE;
            end else begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_msg_writer.sv
// Scoreboard bench for osd_msg_writer: stimulus pushes expected words/transactions,
// a forked bus monitor pops and compares them as strobes and io_osd frames appear.
module tb_osd_msg_writer;

  localparam int LINES    = 8;
  localparam int STROBE_W = 2;
  localparam int GAP      = 4;
  localparam int AW       = 11;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          req_write;
  logic          req_en;
  logic          req_dis;
  logic          busy;
  logic          done;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data;
  logic          io_osd;
  logic          io_strobe;
  logic [15:0]   io_din;

  always #5 clk_sys = ~clk_sys;

  osd_msg_writer #(.LINES(LINES), .STROBE_W(STROBE_W), .GAP(GAP), .AW(AW)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .req_write (req_write),
    .req_en    (req_en),
    .req_dis   (req_dis),
    .busy      (busy),
    .done      (done),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .io_osd    (io_osd),
    .io_strobe (io_strobe),
    .io_din    (io_din)
  );

  // Source memory with one-cycle registered read: byte[a] = a[7:0] ^ a[10:8].
  logic [7:0] mem [0:2047];
  logic [7:0] mem_q;
  always @(posedge clk_sys) mem_q <= mem[src_addr];
  assign src_data = mem_q;

  int checks;
  int failures;
  logic [15:0] exp_word [$];
  int          exp_len  [$];

  int   done_cnt;
  int   strobe_cnt;
  int   osd_rises;
  int   cur_words;
  int   hi_cnt;
  int   viol;
  int   txn_idx;
  bit   mon_ignore;
  logic prev_strobe, prev_osd;
  logic [15:0] prev_din;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_write();
    for (int l = 0; l < LINES; l++) begin
      logic [15:0] w0;
      w0 = 16'h0020 | 16'(l);
      exp_word.push_back(w0);
      for (int k = 1; k <= 256; k++) begin
        logic [7:0] b;
        b = 8'(k - 1) ^ 8'(l);
        exp_word.push_back({8'h00, b});
      end
      exp_len.push_back(257);
    end
  endtask

  task automatic push_cmd(input logic [15:0] w);
    exp_word.push_back(w);
    exp_len.push_back(1);
  endtask

  task automatic pulse(input bit wr, input bit en, input bit dis);
    @(negedge clk_sys);
    req_write = wr;
    req_en    = en;
    req_dis   = dis;
    @(negedge clk_sys);
    req_write = 1'b0;
    req_en    = 1'b0;
    req_dis   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget, output logic busy_at);
    int seen;
    seen    = 0;
    busy_at = 1'b1;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk_sys);
      if (done) begin
        seen++;
        busy_at = busy;
      end
    end
    chk(name, 32'(seen), 32'(n));
  endtask

  initial begin
    logic b_at;
    int   base;
    int   s0;
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] av;
      av = 11'(a);
      mem[a] = av[7:0] ^ {5'b0, av[10:8]};
    end
    checks = 0; failures = 0;
    done_cnt = 0; strobe_cnt = 0; osd_rises = 0; cur_words = 0; hi_cnt = 0;
    viol = 0; txn_idx = 0; mon_ignore = 1'b0;
    prev_strobe = 1'b0; prev_osd = 1'b0; prev_din = 16'd0;
    req_write = 1'b0; req_en = 1'b0; req_dis = 1'b0;
    rst_n = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk_sys);
          if (!rst_n) begin
            prev_strobe = 1'b0; prev_osd = 1'b0; prev_din = 16'd0;
            cur_words = 0; hi_cnt = 0;
          end else begin
            if (io_strobe && !prev_strobe) begin
              cur_words++;
              strobe_cnt++;
              if (!mon_ignore) begin
                if (exp_word.size() == 0) begin
                  chk("unexpected_word", 32'(io_din), 32'hFFFF_FFFF);
                end else begin
                  logic [15:0] ew;
                  ew = exp_word.pop_front();
                  chk("word", 32'(io_din), 32'(ew));
                end
              end
            end
            if (io_strobe && prev_strobe && io_din !== prev_din) viol++;
            if (io_strobe && !io_osd) viol++;
            if (io_osd && !prev_osd) osd_rises++;
            if (io_osd) hi_cnt++;
            if (!io_osd && prev_osd) begin
              $display("txn %0d words=%0d osd_high=%0d", txn_idx, cur_words, hi_cnt);
              txn_idx++;
              if (!mon_ignore) begin
                if (exp_len.size() == 0) begin
                  chk("unexpected_txn", 32'(cur_words), 32'hFFFF_FFFF);
                end else begin
                  int el;
                  el = exp_len.pop_front();
                  chk("txn_words", 32'(cur_words), 32'(el));
                  chk("osd_high", 32'(hi_cnt), 32'(GAP + el * 2 * STROBE_W));
                end
              end
              cur_words = 0;
              hi_cnt = 0;
            end
            if (done) done_cnt++;
            prev_strobe = io_strobe;
            prev_osd    = io_osd;
            prev_din    = io_din;
          end
        end
      end
      begin : stimulus
        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_osd", 32'(io_osd), 32'd0);
        chk("rst_strobe", 32'(io_strobe), 32'd0);
        chk("rst_din", 32'(io_din), 32'd0);
        chk("rst_addr", 32'(src_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Single enable command; busy must fall together with done.
        push_cmd(16'h0041);
        pulse(1'b0, 1'b1, 1'b0);
        chk("en_busy_high", 32'(busy), 32'd1);
        wait_done("en_done", 1, 200, b_at);
        chk("en_busy_at_done", 32'(b_at), 32'd0);
        repeat (5) @(negedge clk_sys);

        // Full bitmap write.
        push_write();
        pulse(1'b1, 1'b0, 1'b0);
        wait_done("wr_done", 1, 12000, b_at);
        chk("wr_busy_at_done", 32'(b_at), 32'd0);
        repeat (5) @(negedge clk_sys);

        // Disable and enable together: disable is served first.
        push_cmd(16'h0040);
        push_cmd(16'h0041);
        pulse(1'b0, 1'b1, 1'b1);
        wait_done("disen_done", 2, 400, b_at);
        repeat (5) @(negedge clk_sys);

        // Enable requests during line 2 are absorbed and wait for the write.
        push_write();
        push_cmd(16'h0041);
        base = osd_rises;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5000 && osd_rises < base + 3; i++) @(negedge clk_sys);
        chk("reach_line2", 32'(osd_rises - base), 32'd3);
        repeat (100) @(negedge clk_sys);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (50) @(negedge clk_sys);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (50) @(negedge clk_sys);
        pulse(1'b0, 1'b1, 1'b0);
        wait_done("wr_en_done", 2, 12000, b_at);
        repeat (20) @(negedge clk_sys);
        chk("done_total", 32'(done_cnt), 32'd6);
        chk("exp_words_left", 32'(exp_word.size()), 32'd0);
        chk("exp_txns_left", 32'(exp_len.size()), 32'd0);
        chk("bus_violations", 32'(viol), 32'd0);

        // Asynchronous reset during the high phase of word 100 of line 1.
        mon_ignore = 1'b1;
        base = osd_rises;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5000 && !(osd_rises == base + 2 && cur_words == 101 && io_strobe); i++)
          @(negedge clk_sys);
        chk("reach_word100", 32'(io_strobe && cur_words == 101), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_osd", 32'(io_osd), 32'd0);
        chk("arst_strobe", 32'(io_strobe), 32'd0);
        chk("arst_din", 32'(io_din), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (2000) @(negedge clk_sys);
        chk("no_strobe_after_rst", 32'(strobe_cnt - s0), 32'd0);
        chk("busy_after_rst", 32'(busy), 32'd0);
        chk("bus_violations_end", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
